dmem_loader: RTL and testbench

Synthesizable preload engine for the data memory. Out of reset, it holds the CPU in reset and accepts a byte stream (header plus little-endian words). It writes each assembled word into `dmem` through the memory's `daddr`/`dwdata`/`dwe` port, then releases the CPU and hands that port over to it. It is the write-side counterpart of the end-of-run memory dump: it puts a test image into `dmem` instead of reading one out.

---
 rtl/dmem_loader.sv | 157 +++++++++++++++
 tb/tb_dmem_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_loader.sv
// dmem_loader: preload engine for the data memory.
// Holds the CPU in reset while a byte stream (16-bit word count followed by
// little-endian 32-bit words) is assembled and written into dmem, then hands
// the dmem data port over to the CPU for the rest of the run.
`timescale 1ns/1ps
module dmem_loader #(
    parameter int DEPTH_WORDS = 128,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] cpu_daddr,
    input  logic [31:0] cpu_dwdata,
    input  logic [3:0]  cpu_dwe,
    output logic [31:0] mem_daddr,
    output logic [31:0] mem_dwdata,
    output logic [3:0]  mem_dwe,
    output logic        cpu_reset,
    output logic        done,
    output logic        dropped
);

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    // One extra bit so comparisons against the depth never overflow.
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH_WORDS);
    localparam logic [CNT_W:0] ONE_C   = (CNT_W+1)'(1);

    state_t             state_q, state_d;
    logic [7:0]         count_lo_q, count_lo_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [1:0]         bsel_q, bsel_d;
    logic [31:0]        word_q, word_d;
    logic               dropped_q, dropped_d;
    logic               cpu_reset_q;

    logic               xfer;
    logic [CNT_W-1:0]   hdr_count;

    assign xfer      = in_valid && in_ready;
    assign hdr_count = CNT_W'({in_data, count_lo_q});

    // Next-state and output decode for the load sequence.
    always_comb begin
        state_d    = state_q;
        count_lo_d = count_lo_q;
        count_d    = count_q;
        idx_d      = idx_q;
        bsel_d     = bsel_q;
        word_d     = word_q;
        dropped_d  = dropped_q;
        in_ready   = 1'b0;
        done       = 1'b0;
        mem_daddr  = 32'({idx_q, 2'b00});
        mem_dwdata = word_q;
        mem_dwe    = 4'h0;

        case (state_q)
            S_HDR0: begin
                in_ready = 1'b1;
                if (xfer) begin
                    count_lo_d = in_data;
                    state_d    = S_HDR1;
                end
            end
            S_HDR1: begin
                in_ready = 1'b1;
                if (xfer) begin
                    count_d = hdr_count;
                    if ({1'b0, hdr_count} > DEPTH_C) begin
                        dropped_d = 1'b1;
                    end
                    if (hdr_count == '0) begin
                        state_d = S_RUN;
                    end else begin
                        idx_d   = '0;
                        bsel_d  = 2'd0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (xfer) begin
                    word_d[{bsel_q, 3'b000} +: 8] = in_data;
                    bsel_d = bsel_q + 2'd1;
                    if (bsel_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // Out-of-range words are consumed but never committed.
                if ({1'b0, idx_q} < DEPTH_C) begin
                    mem_dwe = 4'hF;
                end
                idx_d = idx_q + 1'b1;
                if (({1'b0, idx_q} + ONE_C) == {1'b0, count_q}) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_RUN: begin
                done       = 1'b1;
                mem_daddr  = cpu_daddr;
                mem_dwdata = cpu_dwdata;
                mem_dwe    = cpu_dwe;
            end
            default: begin
                state_d = S_HDR0;
            end
        endcase

        // No write may reach dmem on a reset cycle.
        if (reset) begin
            mem_dwe = 4'h0;
        end
    end

    // State registers; cpu_reset drops on the same edge that enters RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HDR0;
            count_lo_q  <= 8'h00;
            count_q     <= '0;
            idx_q       <= '0;
            bsel_q      <= 2'd0;
            word_q      <= 32'h0;
            dropped_q   <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_lo_q  <= count_lo_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            bsel_q      <= bsel_d;
            word_q      <= word_d;
            dropped_q   <= dropped_d;
            cpu_reset_q <= (state_d != S_RUN);
        end
    end

    assign cpu_reset = cpu_reset_q;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_dmem_loader.sv
// Scoreboard bench for dmem_loader: stimulus pushes expected WRITE-cycle
// contents into a queue, a negedge monitor pops and compares on every WRITE
// cycle, and a behavioural dmem checks final memory contents.
`timescale 1ns/1ps
module tb_dmem_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] cpu_daddr;
    logic [31:0] cpu_dwdata;
    logic [3:0]  cpu_dwe;
    logic [31:0] mem_daddr;
    logic [31:0] mem_dwdata;
    logic [3:0]  mem_dwe;
    logic        cpu_reset;
    logic        done;
    logic        dropped;

    dmem_loader #(.DEPTH_WORDS(128), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cpu_daddr  (cpu_daddr),
        .cpu_dwdata (cpu_dwdata),
        .cpu_dwe    (cpu_dwe),
        .mem_daddr  (mem_daddr),
        .mem_dwdata (mem_dwdata),
        .mem_dwe    (mem_dwe),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .dropped    (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   write_cycles = 0;
    logic clr_mem;
    logic [31:0] mem [0:255];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Behavioural dmem with byte enables.
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (mem_dwe[k]) mem[mem_daddr[9:2]][k*8 +: 8] <= mem_dwdata[k*8 +: 8];
        end
    end

    // Monitor: a WRITE cycle is the only loading cycle with in_ready low.
    always @(negedge clk) begin
        if (!reset && !done) begin
            if (!in_ready) begin
                write_cycles++;
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("FAIL unexpected_write: got addr %h data %h we %h expected none",
                             mem_daddr, mem_dwdata, mem_dwe);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", mem_daddr, e.addr);
                    check("wr_data", mem_dwdata, e.data);
                    check("wr_dwe", {28'h0, mem_dwe}, {28'h0, e.we});
                    $display("write addr=%h data=%h we=%h", mem_daddr, mem_dwdata, mem_dwe);
                end
            end else begin
                check("idle_dwe", {28'h0, mem_dwe}, 32'h0);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit sent;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk); #1;
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        sent = 1'b0;
        for (int t = 0; t < 20 && !sent; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                sent = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!sent) check("byte_accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic send_hdr(input logic [15:0] cnt);
        send_byte(cnt[7:0], 1'b0);
        send_byte(cnt[15:8], 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w, input int idx, input bit gaps);
        exp_t e;
        e.addr = {idx[29:0], 2'b00};
        e.data = w;
        e.we   = (idx < 128) ? 4'hF : 4'h0;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8], gaps);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_reached", {31'h0, seen}, 32'h1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        cpu_daddr = 32'h0; cpu_dwdata = 32'h0; cpu_dwe = 4'h0;
        clr_mem = 1'b1;
        @(posedge clk); #1;
        clr_mem = 1'b0;
        do_reset();

        // Reset state
        check("rst_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_dropped", {31'h0, dropped}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_dwe", {28'h0, mem_dwe}, 32'h0);

        // count=0: RUN on the edge after the second header byte
        send_hdr(16'd0);
        check("c0_cpu_reset", {31'h0, cpu_reset}, 32'h0);
        check("c0_done", {31'h0, done}, 32'h1);
        $display("count0 done=%b cpu_reset=%b", done, cpu_reset);

        // count=2 back-to-back
        do_reset();
        send_hdr(16'd2);
        send_word(32'hDEADBEEF, 0, 1'b0);
        send_word(32'h01234567, 1, 1'b0);
        wait_done();
        check("c2_word0", mem[0], 32'hDEADBEEF);
        check("c2_word1", mem[1], 32'h01234567);
        check("c2_cpu_reset", {31'h0, cpu_reset}, 32'h0);

        // count=128 with random valid gaps
        do_reset();
        write_cycles = 0;
        send_hdr(16'd128);
        for (int i = 0; i < 128; i++) send_word(32'h1000_0000 + i, i, 1'b1);
        wait_done();
        check("c128_write_cycles", write_cycles, 32'd128);
        check("c128_dropped", {31'h0, dropped}, 32'h0);
        for (int i = 0; i < 128; i++) check("c128_word", mem[i], 32'h1000_0000 + i);

        // count=130: overflow words consumed but never written
        do_reset();
        check("c130_dropped_clear", {31'h0, dropped}, 32'h0);
        send_hdr(16'd130);
        check("c130_dropped", {31'h0, dropped}, 32'h1);
        for (int i = 0; i < 130; i++) send_word(32'hA500_0000 + i, i, 1'b0);
        wait_done();
        for (int i = 0; i < 128; i++) check("c130_word", mem[i], 32'hA500_0000 + i);
        check("c130_word128", mem[128], 32'h0);
        check("c130_word129", mem[129], 32'h0);
        check("c130_dropped_sticky", {31'h0, dropped}, 32'h1);

        // Reset mid-word 5
        do_reset();
        send_hdr(16'd8);
        for (int i = 0; i < 5; i++) send_word(32'hB0B0_0000 + i, i, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        do_reset();
        check("mid_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        check("mid_in_ready", {31'h0, in_ready}, 32'h1);
        check("mid_done", {31'h0, done}, 32'h0);
        for (int i = 0; i < 5; i++) check("mid_word", mem[i], 32'hB0B0_0000 + i);
        send_hdr(16'd3);
        for (int i = 0; i < 3; i++) send_word(32'hC0C0_0000 + i, i, 1'b0);
        wait_done();
        for (int i = 0; i < 3; i++) check("reload_word", mem[i], 32'hC0C0_0000 + i);
        check("reload_word4", mem[4], 32'hB0B0_0004);

        // CPU passthrough in RUN
        @(posedge clk); #1;
        cpu_daddr = 32'h10; cpu_dwdata = 32'hCAFEF00D; cpu_dwe = 4'b0011;
        in_data = 8'h5A; in_valid = 1'b1;
        #1;
        check("run_daddr", mem_daddr, 32'h10);
        check("run_dwdata", mem_dwdata, 32'hCAFEF00D);
        check("run_dwe", {28'h0, mem_dwe}, 32'h3);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("run_in_ready", {31'h0, in_ready}, 32'h0);
        end
        @(posedge clk); #1;
        cpu_dwe = 4'h0; in_valid = 1'b0;
        @(posedge clk); #1;
        check("run_cpu_write", mem[4], 32'hB0B0_F00D);
        check("run_done", {31'h0, done}, 32'h1);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
